// File: rtl/logic_op_arbiter.sv
// logic_op_arbiter: one shared bitwise AND/OR/XOR/NOR unit arbitrated among N_REQ requesters.
// Build option: define LOGIC_ARB_FIXED_PRIO_EN for fixed lowest-index priority (default is round-robin).
module logic_op_arbiter #(
  parameter int WIDTH = 32,
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N_REQ-1:0]       req_valid,
  output logic [N_REQ-1:0]       req_ready,
  input  logic [N_REQ*WIDTH-1:0] req_a,
  input  logic [N_REQ*WIDTH-1:0] req_b,
  input  logic [N_REQ*2-1:0]     req_op,
  output logic                   resp_valid,
  input  logic                   resp_ready,
  output logic [ID_W-1:0]        resp_id,
  output logic [WIDTH-1:0]       resp_result,
  output logic                   busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_EXEC = 2'b01,
    S_RESP = 2'b10
  } state_t;

  localparam logic [1:0] OP_AND = 2'b00;
  localparam logic [1:0] OP_OR  = 2'b01;
  localparam logic [1:0] OP_XOR = 2'b10;
  localparam logic [1:0] OP_NOR = 2'b11;

  function automatic logic [WIDTH-1:0] logic_op(input logic [1:0]       op,
                                                input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b);
    logic [WIDTH-1:0] r;
    case (op)
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      OP_NOR:  r = ~(a | b);
      default: r = '0;
    endcase
    return r;
  endfunction

`ifdef LOGIC_ARB_FIXED_PRIO_EN
  function automatic logic [ID_W-1:0] pick_winner(input logic [N_REQ-1:0] valid);
    logic [ID_W-1:0] w;
    w = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      w = valid[i] ? ID_W'(i) : w;
    end
    return w;
  endfunction
`else
  // Wrapped group (index <= last) is scanned first so the upper group overrides it.
  function automatic logic [ID_W-1:0] pick_winner(input logic [N_REQ-1:0] valid,
                                                  input logic [ID_W-1:0]  last);
    logic [ID_W-1:0] w;
    w = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      w = (valid[i] && (i <= int'(last))) ? ID_W'(i) : w;
    end
    for (int i = N_REQ - 1; i >= 0; i--) begin
      w = (valid[i] && (i > int'(last))) ? ID_W'(i) : w;
    end
    return w;
  endfunction
`endif

  state_t           state_r;
  state_t           state_nxt_s;
  logic [ID_W-1:0]  winner_s;
  logic [N_REQ-1:0] grant_s;
  logic             accept_s;
  logic [WIDTH-1:0] sel_a_s;
  logic [WIDTH-1:0] sel_b_s;
  logic [1:0]       sel_op_s;
  logic [WIDTH-1:0] op_a_r;
  logic [WIDTH-1:0] op_b_r;
  logic [1:0]       op_code_r;
  logic [ID_W-1:0]  op_id_r;
  logic [ID_W-1:0]  resp_id_r;
  logic [WIDTH-1:0] resp_result_r;
  logic             resp_valid_r;
  logic             busy_r;

`ifndef LOGIC_ARB_FIXED_PRIO_EN
  logic [ID_W-1:0]  last_g_r;

  // Round-robin pointer: moves only when a request is accepted.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_g_r <= ID_W'(N_REQ - 1);
    end else if (accept_s) begin
      last_g_r <= winner_s;
    end else begin
      last_g_r <= last_g_r;
    end
  end
`endif

  // Winner selection and handshake qualification.
  always_comb begin
`ifdef LOGIC_ARB_FIXED_PRIO_EN
    winner_s = pick_winner(req_valid);
`else
    winner_s = pick_winner(req_valid, last_g_r);
`endif
    accept_s = (state_r == S_IDLE) && (|req_valid) && !reset;
  end

  // One-hot grant and the ready vector offered only while idle.
  always_comb begin
    grant_s = '0;
    for (int i = 0; i < N_REQ; i++) begin
      grant_s[i] = (ID_W'(i) == winner_s);
    end
    req_ready = accept_s ? grant_s : '0;
  end

  // AND-OR operand mux keeps non-granted operands out of the datapath.
  always_comb begin
    sel_a_s  = '0;
    sel_b_s  = '0;
    sel_op_s = 2'b00;
    for (int i = 0; i < N_REQ; i++) begin
      sel_a_s  = sel_a_s  | ({WIDTH{grant_s[i]}} & req_a[i*WIDTH +: WIDTH]);
      sel_b_s  = sel_b_s  | ({WIDTH{grant_s[i]}} & req_b[i*WIDTH +: WIDTH]);
      sel_op_s = sel_op_s | ({2{grant_s[i]}} & req_op[i*2 +: 2]);
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (accept_s) begin
          state_nxt_s = S_EXEC;
        end else begin
          state_nxt_s = S_IDLE;
        end
      end
      S_EXEC: state_nxt_s = S_RESP;
      S_RESP: begin
        if (resp_ready) begin
          state_nxt_s = S_IDLE;
        end else begin
          state_nxt_s = S_RESP;
        end
      end
      default: state_nxt_s = S_IDLE;
    endcase
  end

  // State, registered status outputs and the operand capture stage.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= S_IDLE;
      resp_valid_r <= 1'b0;
      busy_r       <= 1'b0;
      op_a_r       <= '0;
      op_b_r       <= '0;
      op_code_r    <= 2'b00;
      op_id_r      <= '0;
    end else begin
      state_r      <= state_nxt_s;
      resp_valid_r <= (state_nxt_s == S_RESP);
      busy_r       <= (state_nxt_s != S_IDLE);
      if (accept_s) begin
        op_a_r    <= sel_a_s;
        op_b_r    <= sel_b_s;
        op_code_r <= sel_op_s;
        op_id_r   <= winner_s;
      end else begin
        op_a_r    <= op_a_r;
        op_b_r    <= op_b_r;
        op_code_r <= op_code_r;
        op_id_r   <= op_id_r;
      end
    end
  end

  // Result register: written only in EXEC, then held until the next operation.
  always_ff @(posedge clk) begin
    if (reset) begin
      resp_result_r <= '0;
      resp_id_r     <= '0;
    end else if (state_r == S_EXEC) begin
      resp_result_r <= logic_op(op_code_r, op_a_r, op_b_r);
      resp_id_r     <= op_id_r;
    end else begin
      resp_result_r <= resp_result_r;
      resp_id_r     <= resp_id_r;
    end
  end

  assign resp_valid  = resp_valid_r;
  assign resp_result = resp_result_r;
  assign resp_id     = resp_id_r;
  assign busy        = busy_r;

endmodule

// File: tb/tb_logic_op_arbiter.sv
// Self-checking bench for logic_op_arbiter: cycle model plus result scoreboard.
`timescale 1ns/1ps
module tb_logic_op_arbiter;
  localparam int WIDTH  = 32;
  localparam int N_REQ  = 4;
  localparam int ID_W   = 2;
  localparam int S_IDLE = 0;
  localparam int S_EXEC = 1;
  localparam int S_RESP = 2;

  logic                   clk = 1'b0;
  logic                   reset;
  logic [N_REQ-1:0]       req_valid;
  logic [N_REQ-1:0]       req_ready;
  logic [N_REQ*WIDTH-1:0] req_a;
  logic [N_REQ*WIDTH-1:0] req_b;
  logic [N_REQ*2-1:0]     req_op;
  logic                   resp_valid;
  logic                   resp_ready;
  logic [ID_W-1:0]        resp_id;
  logic [WIDTH-1:0]       resp_result;
  logic                   busy;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  bit chk_en  = 1'b0;

  int                    m_state    = S_IDLE;
  int                    m_last     = N_REQ - 1;
  logic [ID_W-1:0]       m_resp_id  = '0;
  logic [WIDTH-1:0]      m_resp_res = '0;
  logic [ID_W+WIDTH-1:0] sb[$];
  int                    dut_grants[$];
  int                    resp_ids[$];
  int                    resp_cyc[$];

  always #5 clk = ~clk;

  logic_op_arbiter #(.WIDTH(WIDTH), .N_REQ(N_REQ), .ID_W(ID_W)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_id(resp_id), .resp_result(resp_result), .busy(busy)
  );

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [WIDTH-1:0] ref_op(input logic [1:0] op, input logic [WIDTH-1:0] a,
                                              input logic [WIDTH-1:0] b);
    case (op)
      2'b00:   return a & b;
      2'b01:   return a | b;
      2'b10:   return a ^ b;
      default: return ~(a | b);
    endcase
  endfunction

  function automatic int ref_pick(input logic [N_REQ-1:0] v, input int last);
`ifdef LOGIC_ARB_FIXED_PRIO_EN
    for (int i = 0; i < N_REQ; i++) if (v[i]) return i;
`else
    for (int k = 1; k <= N_REQ; k++) begin
      int idx;
      idx = (last + k) % N_REQ;
      if (v[idx]) return idx;
    end
`endif
    return 0;
  endfunction

  function automatic logic [N_REQ-1:0] ref_ready();
    logic [N_REQ-1:0] r;
    r = '0;
    if (m_state == S_IDLE && !reset && req_valid != '0) r[ref_pick(req_valid, m_last)] = 1'b1;
    return r;
  endfunction

  // Reference cycle model, advanced on every rising edge.
  initial forever begin
    int g;
    @(posedge clk);
    cyc++;
    if (reset) begin
      m_state    = S_IDLE;
      m_last     = N_REQ - 1;
      m_resp_id  = '0;
      m_resp_res = '0;
      sb.delete();
    end else begin
      case (m_state)
        S_IDLE: if (req_valid != '0) begin
          g = ref_pick(req_valid, m_last);
          m_last = g;
          sb.push_back({ID_W'(g), ref_op(req_op[g*2 +: 2], req_a[g*WIDTH +: WIDTH],
                                         req_b[g*WIDTH +: WIDTH])});
          m_state = S_EXEC;
        end
        S_EXEC: begin
          if (sb.size() > 0) begin
            m_resp_id  = sb[0][ID_W+WIDTH-1:WIDTH];
            m_resp_res = sb[0][WIDTH-1:0];
          end
          m_state = S_RESP;
        end
        default: if (resp_ready) m_state = S_IDLE;
      endcase
    end
  end

  // Per-cycle comparison against the model, sampled on the falling edge.
  initial forever begin
    logic [ID_W+WIDTH-1:0] e;
    @(negedge clk);
    if (chk_en) begin
      check_val("busy", busy, m_state != S_IDLE);
      check_val("resp_valid", resp_valid, m_state == S_RESP);
      check_val("req_ready", req_ready, ref_ready());
      check_val("resp_id_hold", resp_id, m_resp_id);
      check_val("resp_result_hold", resp_result, m_resp_res);
      for (int i = 0; i < N_REQ; i++) if (req_valid[i] && req_ready[i]) dut_grants.push_back(i);
      if (m_state == S_RESP && resp_ready && !reset) begin
        resp_ids.push_back(int'(resp_id));
        resp_cyc.push_back(cyc);
        check_val("sb_depth", sb.size() > 0, 1'b1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          check_val("sb_resp_id", resp_id, e[ID_W+WIDTH-1:WIDTH]);
          check_val("sb_resp_result", resp_result, e[WIDTH-1:0]);
        end
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_req(input int i, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic [1:0] op);
    req_a[i*WIDTH +: WIDTH] = a;
    req_b[i*WIDTH +: WIDTH] = b;
    req_op[i*2 +: 2]        = op;
  endtask

  task automatic wait_resp(input string tag);
    int k;
    k = 0;
    while (!resp_valid && k < 20) begin
      tick();
      k++;
    end
    check_val(tag, resp_valid, 1'b1);
  endtask

  logic [1:0]       sweep_op[3]  = '{2'b01, 2'b10, 2'b11};
  logic [WIDTH-1:0] sweep_exp[3] = '{32'h00FF_FFFF, 32'h00FF_FF00, 32'hFF00_0000};
`ifdef LOGIC_ARB_FIXED_PRIO_EN
  int exp_grants[5] = '{0, 0, 0, 0, 0};
`else
  int exp_grants[5] = '{0, 1, 2, 3, 0};
`endif

  initial begin
    int base;
    int cnt2;
    reset      = 1'b1;
    req_valid  = 4'b1111;
    resp_ready = 1'b1;
    req_a      = 'x;
    req_b      = 'x;
    req_op     = 'x;
    tick(2);
    chk_en = 1'b1;
    check_val("rst_req_ready", req_ready, 4'b0000);
    check_val("rst_busy", busy, 1'b0);
    check_val("rst_resp_valid", resp_valid, 1'b0);
    check_val("rst_resp_id", resp_id, 2'd0);
    check_val("rst_resp_result", resp_result, 32'd0);
    req_valid = 4'b0000;
    reset     = 1'b0;
    tick();

    // Single request on requester 0, other operands left unknown.
    set_req(0, 32'hF0F0_F0F0, 32'hFF00_FF00, 2'b00);
    req_valid = 4'b0001;
    #1;
    check_val("single_ready", req_ready, 4'b0001);
    tick();
    req_valid = 4'b0000;
    check_val("single_lat_exec", resp_valid, 1'b0);
    tick();
    check_val("single_lat_resp", resp_valid, 1'b1);
    check_val("single_result", resp_result, 32'hF000_F000);
    check_val("single_id", resp_id, 2'd0);
    tick();

    // Opcode sweep on requester 2.
    for (int s = 0; s < 3; s++) begin
      set_req(2, 32'h0000_FFFF, 32'h00FF_00FF, sweep_op[s]);
      req_valid = 4'b0100;
      tick();
      req_valid = 4'b0000;
      wait_resp("sweep_timeout");
      check_val("sweep_result", resp_result, sweep_exp[s]);
      check_val("sweep_id", resp_id, 2'd2);
      tick();
    end

    // Round-robin with all requesters valid and resp_ready held high.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    dut_grants.delete();
    resp_cyc.delete();
    set_req(0, 32'h1111_0000, 32'h0101_0101, 2'b00);
    set_req(1, 32'h2222_0000, 32'h0202_0202, 2'b01);
    set_req(2, 32'h3333_0000, 32'h0303_0303, 2'b10);
    set_req(3, 32'h4444_0000, 32'h0404_0404, 2'b11);
    req_valid = 4'b1111;
    tick(15);
    req_valid = 4'b0000;
    tick(4);
    check_val("rr_grant_count", dut_grants.size() >= 5, 1'b1);
    for (int i = 0; i < 5 && i < dut_grants.size(); i++) check_val("rr_grant", dut_grants[i], exp_grants[i]);
    check_val("rr_resp_count", resp_cyc.size() >= 5, 1'b1);
    for (int i = 1; i < 5 && i < resp_cyc.size(); i++) check_val("rr_period", resp_cyc[i] - resp_cyc[i-1], 3);

    // Backpressure with a withdrawn request from requester 2 while busy.
    base = resp_ids.size();
    resp_ready = 1'b0;
    set_req(1, 32'h1234_5678, 32'h0F0F_0F0F, 2'b10);
    req_a[2*WIDTH +: WIDTH] = 'x;
    req_valid = 4'b0010;
    tick();
    req_valid = 4'b0100;
    wait_resp("bp_timeout");
    for (int k = 0; k < 5; k++) begin
      if (k == 2) req_valid = 4'b0000;
      #1;
      check_val("bp_valid", resp_valid, 1'b1);
      check_val("bp_id", resp_id, 2'd1);
      check_val("bp_result", resp_result, 32'h1D3B_5977);
      check_val("bp_req_ready", req_ready, 4'b0000);
      check_val("bp_busy", busy, 1'b1);
      tick();
    end
    resp_ready = 1'b1;
    tick();
    check_val("bp_release", resp_valid, 1'b0);
    tick(5);
    cnt2 = 0;
    for (int i = base; i < resp_ids.size(); i++) if (resp_ids[i] == 2) cnt2++;
    check_val("withdrawn_no_id2", cnt2, 0);
    check_val("bp_resp_seen", resp_ids.size() - base, 1);

    // Reset asserted while in EXEC.
    set_req(3, 32'hAAAA_5555, 32'h0000_FFFF, 2'b00);
    req_valid = 4'b1000;
    tick();
    req_valid = 4'b0000;
    reset     = 1'b1;
    tick();
    check_val("midrst_busy", busy, 1'b0);
    check_val("midrst_resp_valid", resp_valid, 1'b0);
    check_val("midrst_resp_result", resp_result, 32'd0);
    check_val("midrst_resp_id", resp_id, 2'd0);
    reset = 1'b0;
    set_req(0, 32'hC3C3_C3C3, 32'h0F0F_0F0F, 2'b01);
    set_req(1, 32'h0000_0001, 32'h0000_0002, 2'b00);
    req_valid = 4'b1011;
    #1;
    check_val("midrst_ready", req_ready, 4'b0001);
    tick();
    req_valid = 4'b0000;
    wait_resp("midrst_timeout");
    check_val("midrst_id", resp_id, 2'd0);
    check_val("midrst_result", resp_result, 32'hCFCF_CFCF);
    tick(3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
